pic_host_sequencer: RTL and testbench

Host-side bus sequencer for the 8259A-style PIC top module. It drives the PIC's CS/WR/A0/data-in pins to run the ICW initialisation sequence and runtime OCW writes. It also answers the PIC's INT output with the two-pulse INTA acknowledge cycle and captures the vector the PIC places on its data-out bus. It sits between a simple host request interface and the PIC pins, owns all PIC strobe timing, and arbitrates between init, acknowledge and OCW traffic.

---
 rtl/pic_host_sequencer_if.sv | 44 ++++
 rtl/pic_host_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_pic_host_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_host_sequencer_if.sv
// Host request and PIC pin bundle for pic_host_sequencer.
// master: the sequencer side. It drives the PIC strobes and the host status signals.
// slave : the host/PIC side. It drives requests, ICW contents, INT and the PIC output data.
// Signals:
//   init_start, icw1..icw4        host init request and ICW bytes
//   ocw_valid/ocw_a0/ocw_data     host OCW request
//   ocw_ready                     OCW handshake
//   INT, pic_data_in              PIC interrupt line and PIC output data bus
//   CS, WR, INTA                  active-low PIC strobes
//   A0, pic_data_out              PIC register select and PIC input data bus
//   int_vector, vector_valid      captured vector and its one-cycle strobe
//   init_done, busy               status
interface pic_host_sequencer_if;
  logic       init_start;
  logic [7:0] icw1;
  logic [7:0] icw2;
  logic [7:0] icw3;
  logic [7:0] icw4;
  logic       ocw_valid;
  logic       ocw_a0;
  logic [7:0] ocw_data;
  logic       ocw_ready;
  logic       INT;
  logic [7:0] pic_data_in;
  logic       CS;
  logic       WR;
  logic       INTA;
  logic       A0;
  logic [7:0] pic_data_out;
  logic [7:0] int_vector;
  logic       vector_valid;
  logic       init_done;
  logic       busy;

  modport master (
    input  init_start, icw1, icw2, icw3, icw4, ocw_valid, ocw_a0, ocw_data, INT, pic_data_in,
    output ocw_ready, CS, WR, INTA, A0, pic_data_out, int_vector, vector_valid, init_done, busy
  );

  modport slave (
    output init_start, icw1, icw2, icw3, icw4, ocw_valid, ocw_a0, ocw_data, INT, pic_data_in,
    input  ocw_ready, CS, WR, INTA, A0, pic_data_out, int_vector, vector_valid, init_done, busy
  );
endinterface

// File: rtl/pic_host_sequencer.sv
// Host-side bus sequencer for an 8259A-style PIC.
// The sequencer runs the ICW init sequence and runtime OCW writes on CS/WR/A0/data.
// It also answers INT with a two-pulse INTA acknowledge and captures the returned vector.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   bus    pic_host_sequencer_if.master: host requests and status, PIC pins
// Parameters:
//   PULSE_CYCLES  low time of every WR/INTA pulse (>= 1)
//   GAP_CYCLES    recovery time with all strobes high after each pulse (>= 1)
module pic_host_sequencer #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input logic                  clk,
  input logic                  reset,
  pic_host_sequencer_if.master bus
);

  localparam int unsigned MaxCycles = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYCLES - 1);

  // StDoneAck is the closing gap of an acknowledge; vector_valid is high in its first cycle.
  typedef enum logic [1:0] {StIdle, StPulse, StGap, StDoneAck} state_e;
  typedef enum logic [1:0] {OpInit, OpAck, OpOcw} op_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            ack_second_q, ack_second_d;
  logic            pend_init_q, pend_init_d;
  logic            init_done_q, init_done_d;
  logic [3:0][7:0] icw_q, icw_d;
  logic            cs_q, cs_d;
  logic            wr_q, wr_d;
  logic            inta_q, inta_d;
  logic            a0_q, a0_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      vec_q, vec_d;
  logic            vec_valid_q, vec_valid_d;

  logic       idle;
  logic       init_req;
  logic       ocw_ready;
  logic       has_next;
  logic [1:0] next_idx;

  assign idle = (state_q == StIdle);
  // An init_start arriving this cycle already blocks ack/OCW acceptance so init wins.
  assign init_req  = pend_init_q | bus.init_start;
  assign ocw_ready = idle & init_done_q & ~init_req & ~bus.INT;

  // Next ICW index: ICW3 only in cascade mode (icw1[1]=0), ICW4 only if IC4 (icw1[0]=1).
  always_comb begin
    next_idx = idx_q;
    has_next = 1'b0;
    case (idx_q)
      2'd0: begin
        next_idx = 2'd1;
        has_next = 1'b1;
      end
      2'd1: begin
        if (!icw_q[0][1]) begin
          next_idx = 2'd2;
          has_next = 1'b1;
        end else if (icw_q[0][0]) begin
          next_idx = 2'd3;
          has_next = 1'b1;
        end
      end
      2'd2: begin
        if (icw_q[0][0]) begin
          next_idx = 2'd3;
          has_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    ack_second_d = ack_second_q;
    pend_init_d  = pend_init_q | bus.init_start;
    init_done_d  = init_done_q;
    icw_d        = icw_q;
    cs_d         = cs_q;
    wr_d         = wr_q;
    inta_d       = inta_q;
    a0_d         = a0_q;
    dout_d       = dout_q;
    vec_d        = vec_q;
    vec_valid_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (pend_init_q) begin
          pend_init_d = 1'b0;
          init_done_d = 1'b0;
          icw_d       = {bus.icw4, bus.icw3, bus.icw2, bus.icw1};
          op_d        = OpInit;
          idx_d       = 2'd0;
          state_d     = StPulse;
          cnt_d       = PulseLoad;
          cs_d        = 1'b0;
          wr_d        = 1'b0;
          a0_d        = 1'b0;
          dout_d      = bus.icw1;
        end else if (bus.INT && init_done_q && !bus.init_start) begin
          op_d         = OpAck;
          ack_second_d = 1'b0;
          state_d      = StPulse;
          cnt_d        = PulseLoad;
          inta_d       = 1'b0;
        end else if (bus.ocw_valid && ocw_ready) begin
          op_d    = OpOcw;
          state_d = StPulse;
          cnt_d   = PulseLoad;
          cs_d    = 1'b0;
          wr_d    = 1'b0;
          a0_d    = bus.ocw_a0;
          dout_d  = bus.ocw_data;
        end
      end

      StPulse: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          cnt_d  = GapLoad;
          cs_d   = 1'b1;
          wr_d   = 1'b1;
          inta_d = 1'b1;
          if (op_q == OpAck && ack_second_q) begin
            // Last cycle of the second INTA pulse: the PIC is driving the vector.
            vec_d       = bus.pic_data_in;
            vec_valid_d = 1'b1;
            state_d     = StDoneAck;
          end else begin
            state_d = StGap;
          end
        end
      end

      StGap: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          case (op_q)
            OpAck: begin
              state_d      = StPulse;
              cnt_d        = PulseLoad;
              inta_d       = 1'b0;
              ack_second_d = 1'b1;
            end
            OpInit: begin
              if (has_next) begin
                state_d = StPulse;
                cnt_d   = PulseLoad;
                cs_d    = 1'b0;
                wr_d    = 1'b0;
                idx_d   = next_idx;
                a0_d    = 1'b1;
                dout_d  = icw_q[next_idx];
              end else begin
                state_d     = StIdle;
                init_done_d = 1'b1;
              end
            end
            default: state_d = StIdle;
          endcase
        end
      end

      StDoneAck: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= OpInit;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      ack_second_q <= 1'b0;
      pend_init_q  <= 1'b0;
      init_done_q  <= 1'b0;
      icw_q        <= '0;
      cs_q         <= 1'b1;
      wr_q         <= 1'b1;
      inta_q       <= 1'b1;
      a0_q         <= 1'b0;
      dout_q       <= 8'h00;
      vec_q        <= 8'h00;
      vec_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      ack_second_q <= ack_second_d;
      pend_init_q  <= pend_init_d;
      init_done_q  <= init_done_d;
      icw_q        <= icw_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      inta_q       <= inta_d;
      a0_q         <= a0_d;
      dout_q       <= dout_d;
      vec_q        <= vec_d;
      vec_valid_q  <= vec_valid_d;
    end
  end

  assign bus.ocw_ready    = ocw_ready;
  assign bus.CS           = cs_q;
  assign bus.WR           = wr_q;
  assign bus.INTA         = inta_q;
  assign bus.A0           = a0_q;
  assign bus.pic_data_out = dout_q;
  assign bus.int_vector   = vec_q;
  assign bus.vector_valid = vec_valid_q;
  assign bus.init_done    = init_done_q;
  assign bus.busy         = ~idle;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Self-checking bench for pic_host_sequencer with PULSE_CYCLES=2 and GAP_CYCLES=1.
// A cycle table covers single-mode init, acknowledge and an OCW write.
// Hand-written sequences cover the cascade init, the collision, reset mid-write and init during ack.
module tb_pic_host_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pic_host_sequencer_if bus ();

  pic_host_sequencer #(
    .PULSE_CYCLES(2),
    .GAP_CYCLES  (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the falling edge.
  logic [16:0] wr_log[$];    // {a0, data, width}
  logic [7:0]  inta_log[$];  // pulse widths
  logic [7:0]  ev_log[$];    // 1 = INTA pulse, 2 = write pulse, in completion order
  int          wr_run = 0;
  int          inta_run = 0;
  logic        wr_a0;
  logic [7:0]  wr_data;
  int          vv_cnt = 0;
  int          overlap = 0;

  always @(negedge clk) begin
    if (!bus.CS && !bus.WR) begin
      wr_run++;
      wr_a0   = bus.A0;
      wr_data = bus.pic_data_out;
    end else if (wr_run != 0) begin
      wr_log.push_back({wr_a0, wr_data, wr_run[7:0]});
      ev_log.push_back(8'd2);
      wr_run = 0;
    end
    if (!bus.INTA) begin
      inta_run++;
      if (!bus.CS || !bus.WR) overlap++;
    end else if (inta_run != 0) begin
      inta_log.push_back(inta_run[7:0]);
      ev_log.push_back(8'd1);
      inta_run = 0;
    end
    if (bus.vector_valid) vv_cnt++;
  end

  task automatic mon_clear();
    wr_log.delete();
    inta_log.delete();
    ev_log.delete();
    vv_cnt  = 0;
    overlap = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.init_start  = 1'b0;
    bus.ocw_valid   = 1'b0;
    bus.ocw_a0      = 1'b0;
    bus.ocw_data    = 8'h00;
    bus.INT         = 1'b0;
    bus.pic_data_in = 8'h00;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_icw(input logic [7:0] i1, i2, i3, i4);
    bus.icw1 = i1;
    bus.icw2 = i2;
    bus.icw3 = i3;
    bus.icw4 = i4;
  endtask

  // Run an init from idle and check write list, latency and init_done.
  task automatic run_init(input string name, input logic [7:0] i1, i2, i3, i4);
    logic [16:0] exp_wr[$];
    int          k;
    exp_wr.push_back({1'b0, i1, 8'd2});
    exp_wr.push_back({1'b1, i2, 8'd2});
    if (!i1[1]) exp_wr.push_back({1'b1, i3, 8'd2});
    if (i1[0]) exp_wr.push_back({1'b1, i4, 8'd2});
    set_icw(i1, i2, i3, i4);
    mon_clear();
    bus.init_start = 1'b1;
    step();
    bus.init_start = 1'b0;
    step();
    check({name, " init_done cleared"}, {63'd0, bus.init_done}, 64'd0);
    k = 0;
    while (!bus.init_done && k < 40) begin
      step();
      k++;
    end
    check({name, " latency"}, 64'(k), 64'(3 * exp_wr.size()));
    check({name, " write count"}, 64'(wr_log.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++) begin
      check($sformatf("%s write %0d", name, i),
            64'((i < wr_log.size()) ? wr_log[i] : 17'h1ffff), 64'(exp_wr[i]));
    end
    check({name, " no INTA"}, 64'(inta_log.size()), 64'd0);
  endtask

  typedef struct {
    logic [19:0] in;   // {init_start, INT, ocw_valid, ocw_a0, ocw_data, pic_data_in}
    logic [23:0] exp;  // {CS, WR, INTA, A0, dout, busy, init_done, vector_valid, int_vector, ocw_ready}
  } row_t;

  function automatic row_t row(input logic is, it, ov, oa, input logic [7:0] od, pd,
                               input logic cs, wr, ia, a0, input logic [7:0] dout,
                               input logic bsy, dn, vv, input logic [7:0] vec, input logic rdy);
    row_t r;
    r.in  = {is, it, ov, oa, od, pd};
    r.exp = {cs, wr, ia, a0, dout, bsy, dn, vv, vec, rdy};
    return r;
  endfunction

  row_t tbl[25];
  int   k;
  logic got_hs;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Single-mode init 0x13/0x20/0x01, acknowledge with vector 0x45, then one OCW.
    tbl[0]  = row(1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    tbl[1]  = row(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    tbl[2]  = row(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h13, 1, 0, 0, 8'h00, 0);
    tbl[3]  = row(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h13, 1, 0, 0, 8'h00, 0);
    tbl[4]  = row(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'h13, 1, 0, 0, 8'h00, 0);
    tbl[5]  = row(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h20, 1, 0, 0, 8'h00, 0);
    tbl[6]  = row(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h20, 1, 0, 0, 8'h00, 0);
    tbl[7]  = row(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 8'h20, 1, 0, 0, 8'h00, 0);
    tbl[8]  = row(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h01, 1, 0, 0, 8'h00, 0);
    tbl[9]  = row(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h01, 1, 0, 0, 8'h00, 0);
    tbl[10] = row(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 8'h01, 1, 0, 0, 8'h00, 0);
    tbl[11] = row(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 8'h01, 0, 1, 0, 8'h00, 1);
    tbl[12] = row(0, 1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 8'h01, 0, 1, 0, 8'h00, 0);
    tbl[13] = row(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 8'h01, 1, 1, 0, 8'h00, 0);
    tbl[14] = row(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 8'h01, 1, 1, 0, 8'h00, 0);
    tbl[15] = row(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 8'h01, 1, 1, 0, 8'h00, 0);
    tbl[16] = row(0, 0, 0, 0, 8'h00, 8'h99, 1, 1, 0, 1, 8'h01, 1, 1, 0, 8'h00, 0);
    tbl[17] = row(0, 0, 0, 0, 8'h00, 8'h45, 1, 1, 0, 1, 8'h01, 1, 1, 0, 8'h00, 0);
    tbl[18] = row(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 8'h01, 1, 1, 1, 8'h45, 0);
    tbl[19] = row(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 8'h01, 0, 1, 0, 8'h45, 1);
    tbl[20] = row(0, 0, 1, 1, 8'hFE, 8'h00, 1, 1, 1, 1, 8'h01, 0, 1, 0, 8'h45, 1);
    tbl[21] = row(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'hFE, 1, 1, 0, 8'h45, 0);
    tbl[22] = row(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'hFE, 1, 1, 0, 8'h45, 0);
    tbl[23] = row(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 8'hFE, 1, 1, 0, 8'h45, 0);
    tbl[24] = row(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 1, 8'hFE, 0, 1, 0, 8'h45, 1);

    set_icw(8'h13, 8'h20, 8'h00, 8'h01);
    do_reset();
    for (int i = 0; i < 25; i++) begin
      {bus.init_start, bus.INT, bus.ocw_valid, bus.ocw_a0, bus.ocw_data, bus.pic_data_in} =
        tbl[i].in;
      #1;
      check($sformatf("table row %0d", i),
            64'({bus.CS, bus.WR, bus.INTA, bus.A0, bus.pic_data_out, bus.busy, bus.init_done,
                 bus.vector_valid, bus.int_vector, bus.ocw_ready}),
            64'(tbl[i].exp));
      step();
    end
    clear_inputs();

    // Init variants: cascade with IC4, cascade without IC4, single without IC4.
    run_init("cascade", 8'h11, 8'h30, 8'h04, 8'h01);
    run_init("cascade no ic4", 8'h10, 8'h40, 8'h0F, 8'hEE);
    run_init("single no ic4", 8'h12, 8'h50, 8'h77, 8'h88);

    // Collision: INT and an OCW in the same idle cycle; the ack goes first.
    mon_clear();
    bus.INT         = 1'b1;
    bus.ocw_valid   = 1'b1;
    bus.ocw_a0      = 1'b0;
    bus.ocw_data    = 8'h20;
    bus.pic_data_in = 8'h77;
    #1;
    check("collision ocw_ready", {63'd0, bus.ocw_ready}, 64'd0);
    step();
    bus.INT = 1'b0;
    got_hs  = 1'b0;
    k       = 0;
    while (!got_hs && k < 30) begin
      if (bus.ocw_ready) got_hs = 1'b1;
      step();
      k++;
    end
    bus.ocw_valid = 1'b0;
    check("collision handshake", {63'd0, got_hs}, 64'd1);
    k = 0;
    while (bus.busy && k < 20) begin
      step();
      k++;
    end
    step();
    check("collision order", 64'({ev_log.size() > 0 ? ev_log[0] : 8'hff,
                                  ev_log.size() > 1 ? ev_log[1] : 8'hff,
                                  ev_log.size() > 2 ? ev_log[2] : 8'hff, 8'(ev_log.size())}),
          64'({8'd1, 8'd1, 8'd2, 8'd3}));
    check("collision inta widths", 64'({inta_log.size() > 0 ? inta_log[0] : 8'hff,
                                        inta_log.size() > 1 ? inta_log[1] : 8'hff}),
          64'({8'd2, 8'd2}));
    check("collision ocw write", 64'(wr_log.size() > 0 ? wr_log[0] : 17'h1ffff),
          64'({1'b0, 8'h20, 8'd2}));
    check("collision vector", 64'(bus.int_vector), 64'h77);
    check("collision vector_valid count", 64'(vv_cnt), 64'd1);
    check("collision strobe overlap", 64'(overlap), 64'd0);

    // Reset in the second cycle of the ICW2 pulse.
    set_icw(8'h13, 8'h20, 8'h00, 8'h01);
    bus.init_start = 1'b1;
    step();
    bus.init_start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("pre-reset icw2 pulse", 64'({bus.CS, bus.WR, bus.A0, bus.pic_data_out}),
          64'({1'b0, 1'b0, 1'b1, 8'h20}));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset mid-write outputs",
          64'({bus.CS, bus.WR, bus.INTA, bus.A0, bus.pic_data_out, bus.busy, bus.init_done,
               bus.vector_valid, bus.int_vector}),
          64'({1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}));
    step();
    mon_clear();
    bus.INT = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("INT ignored before init", 64'({8'(inta_log.size()), 7'd0, bus.busy, 7'd0, bus.INTA}),
          64'({8'd0, 7'd0, 1'b0, 7'd0, 1'b1}));
    bus.INT = 1'b0;

    // Init requested during the first INTA pulse.
    run_init("pre-ack init", 8'h13, 8'h21, 8'h00, 8'h03);
    mon_clear();
    bus.INT         = 1'b1;
    bus.pic_data_in = 8'h5A;
    step();
    check("ack started", {63'd0, bus.INTA}, 64'd0);
    bus.init_start = 1'b1;
    step();
    bus.init_start = 1'b0;
    k = 0;
    while (bus.init_done && k < 20) begin
      step();
      k++;
    end
    check("init_done cleared after ack", 64'(k), 64'd6);
    k = 0;
    while (!bus.init_done && k < 40) begin
      step();
      k++;
    end
    check("init after ack latency", 64'(k), 64'd9);
    check("ack then init order",
          64'({ev_log.size() > 0 ? ev_log[0] : 8'hff, ev_log.size() > 1 ? ev_log[1] : 8'hff,
               ev_log.size() > 2 ? ev_log[2] : 8'hff, ev_log.size() > 3 ? ev_log[3] : 8'hff,
               ev_log.size() > 4 ? ev_log[4] : 8'hff, 8'(ev_log.size())}),
          64'({8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd5}));
    check("ack during init vector", 64'(bus.int_vector), 64'h5A);
    step();
    check("INT served after init", {63'd0, bus.INTA}, 64'd0);
    bus.INT = 1'b0;
    k = 0;
    while (bus.busy && k < 20) begin
      step();
      k++;
    end
    check("final idle", {63'd0, bus.busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
